// File: rtl/dsp_pkg.sv
// dsp_pkg: shared DSP types and constant helpers for the power blocks.
package dsp_pkg;
    typedef enum logic {
        SQUARE      = 1'b0,
        MEAN_SQUARE = 1'b1
    } mode_t;
    function automatic int win_bits(input int max_log2);
        return (max_log2 > 0) ? $clog2(max_log2 + 1) : 1;
    endfunction
    // Right shift that turns the full-precision square into 2*INT_BITS integer bits.
    function automatic int sq_shift(input int width, input int frac);
        return 2 * frac - (width - 2 * (width - frac));
    endfunction
endpackage

// File: rtl/axis_if.sv
// Axis_If: minimal AXI-stream bundle (data, valid, ready, last).
interface Axis_If #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic             last;
    modport master(output data, valid, last, input ready);
    modport slave(input data, valid, last, output ready);
endinterface

// File: rtl/axis_power_lane.sv
// axis_power_lane: one lane of square, delay, window accumulate and output register;
// all handshake and window decisions arrive from the top as per-stage controls.
module axis_power_lane
    import dsp_pkg::*;
#(
    parameter int SAMPLE_WIDTH     = 16,
    parameter int SAMPLE_FRAC_BITS = 14,
    parameter int PIPE_STAGES      = 3,
    parameter int MAX_LOG2_WINDOW  = 8,
    parameter int WIN_BITS         = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_en,
    input  logic [SAMPLE_WIDTH-1:0] i_x,
    input  logic                    i_v,
    input  logic                    i_acc,
    input  logic                    i_av,
    input  logic [WIN_BITS-1:0]     i_aw,
    output logic [SAMPLE_WIDTH-1:0] o_data
);
    localparam int D  = PIPE_STAGES - 1;
    localparam int AW = SAMPLE_WIDTH + MAX_LOG2_WINDOW;
    localparam int SH = sq_shift(SAMPLE_WIDTH, SAMPLE_FRAC_BITS);
    logic signed [2*SAMPLE_WIDTH-1:0] w_prod;
    logic        [SAMPLE_WIDTH-1:0]   r_sq [D];
    logic        [SAMPLE_WIDTH-1:0]   r_out;
    logic        [AW-1:0]             r_acc;
    logic        [AW-1:0]             w_acc_n;
    always_comb begin
        w_prod  = $signed(i_x) * $signed(i_x);
        // A pending close empties the accumulator in the same edge a new beat may enter it.
        w_acc_n = (i_av ? '0 : r_acc) + ((i_v && (i_acc || i_av)) ? AW'(r_sq[D-1]) : '0);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sq  <= '{default: '0};
            r_acc <= '0;
            r_out <= '0;
        end else if (i_en) begin
            r_sq[0] <= SAMPLE_WIDTH'(w_prod >>> SH);
            for (int k = 1; k < D; k++) r_sq[k] <= r_sq[k-1];
            r_acc <= w_acc_n;
            r_out <= i_av ? SAMPLE_WIDTH'(r_acc >> i_aw) : ((i_v && !i_acc) ? r_sq[D-1] : r_out);
        end
    end
    assign o_data = r_out;
endmodule

// File: rtl/axis_power.sv
// axis_power: per-lane power of signed samples, either squared beat by beat or
// averaged over 2^W beats; one global enable stalls the whole pipeline.
module axis_power
    import dsp_pkg::*;
#(
    parameter int SAMPLE_WIDTH     = 16,
    parameter int PARALLEL_SAMPLES = 2,
    parameter int SAMPLE_FRAC_BITS = 14,
    parameter int PIPE_STAGES      = 3,
    parameter int MAX_LOG2_WINDOW  = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    Axis_If.slave                                data_in,
    Axis_If.master                               data_out,
    input  mode_t                                mode,
    input  logic [win_bits(MAX_LOG2_WINDOW)-1:0] log2_window
);
    localparam int WW = win_bits(MAX_LOG2_WINDOW);
    localparam int D  = PIPE_STAGES - 1;
    localparam int CW = (MAX_LOG2_WINDOW > 0) ? MAX_LOG2_WINDOW : 1;
    typedef struct packed {
        logic          v;
        logic          last;
        logic          acc;
        logic          close;
        logic [WW-1:0] w;
    } stg_t;
    stg_t                    r_stg [D];
    mode_t                   r_mode;
    mode_t                   w_mode;
    logic [WW-1:0]           r_w;
    logic [WW-1:0]           w_w;
    logic [WW-1:0]           w_lw;
    logic [WW-1:0]           r_aw;
    logic [CW-1:0]           r_cnt;
    logic                    w_en;
    logic                    w_take;
    logic                    w_first;
    logic                    w_acc;
    logic                    w_close;
    logic                    w_pass;
    logic                    w_av_n;
    logic                    r_av;
    logic                    r_alast;
    logic                    r_ov;
    logic                    r_olast;
    logic [SAMPLE_WIDTH-1:0] w_lane [PARALLEL_SAMPLES];
    always_comb begin
        w_en    = !reset && (!r_ov || data_out.ready);
        w_take  = w_en && data_in.valid;
        w_first = r_cnt == '0;
        w_lw    = (log2_window > WW'(MAX_LOG2_WINDOW)) ? WW'(MAX_LOG2_WINDOW) : log2_window;
        w_mode  = w_first ? mode : r_mode;
        w_w     = w_first ? w_lw : r_w;
        w_acc   = (w_mode == MEAN_SQUARE) && (w_w != '0);
        w_close = data_in.last || (r_cnt == CW'((1 << w_w) - 1));
        // A direct beat trailing a window close by one stage is folded into the
        // accumulator stage as a one-beat window so output order is preserved.
        w_pass  = r_stg[D-1].v && !r_stg[D-1].acc && !r_av;
        w_av_n  = r_stg[D-1].v && (r_stg[D-1].acc ? r_stg[D-1].close : r_av);
    end
    assign data_in.ready  = w_en;
    assign data_out.valid = r_ov;
    assign data_out.last  = r_olast;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stg   <= '{default: '0};
            r_mode  <= SQUARE;
            r_w     <= '0;
            r_cnt   <= '0;
            r_av    <= 1'b0;
            r_alast <= 1'b0;
            r_aw    <= '0;
            r_ov    <= 1'b0;
            r_olast <= 1'b0;
        end else if (w_en) begin
            if (w_take && w_first) begin
                r_mode <= mode;
                r_w    <= w_lw;
            end
            if (w_take) r_cnt <= (w_acc && !w_close) ? r_cnt + 1'b1 : '0;
            r_stg[0] <= '{v: w_take, last: data_in.last, acc: w_acc, close: w_close, w: w_w};
            for (int k = 1; k < D; k++) r_stg[k] <= r_stg[k-1];
            r_av    <= w_av_n;
            r_alast <= r_stg[D-1].last;
            r_aw    <= r_stg[D-1].acc ? r_stg[D-1].w : '0;
            r_ov    <= r_av || w_pass;
            r_olast <= r_av ? r_alast : (w_pass && r_stg[D-1].last);
        end
    end
    for (genvar g = 0; g < PARALLEL_SAMPLES; g++) begin : g_lane
        axis_power_lane #(
            .SAMPLE_WIDTH    (SAMPLE_WIDTH),
            .SAMPLE_FRAC_BITS(SAMPLE_FRAC_BITS),
            .PIPE_STAGES     (PIPE_STAGES),
            .MAX_LOG2_WINDOW (MAX_LOG2_WINDOW),
            .WIN_BITS        (WW)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .i_en  (w_en),
            .i_x   (data_in.data[g*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
            .i_v   (r_stg[D-1].v),
            .i_acc (r_stg[D-1].acc),
            .i_av  (r_av),
            .i_aw  (r_aw),
            .o_data(w_lane[g])
        );
    end
    always_comb begin
        data_out.data = '0;
        for (int i = 0; i < PARALLEL_SAMPLES; i++) data_out.data[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = w_lane[i];
    end
endmodule

// File: tb/tb_axis_power.sv
// tb_axis_power: directed and random scoreboard bench for axis_power.
module tb_axis_power;
    import dsp_pkg::*;
    localparam int SW = 16, PS = 2, P = 3, MW = 8, WW = win_bits(MW), DW = SW * PS;
    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        int            due;
    } exp_t;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    mode_t         mode_i = SQUARE;
    logic [WW-1:0] lw_i = '0;
    logic          rdy_rand = 1'b0;
    logic          use_model = 1'b0;
    int            checks = 0, errors = 0, cyc = 0;
    exp_t          q[$];
    int            m_cnt = 0, m_w = 0;
    mode_t         m_mode = SQUARE;
    longint        m_acc0 = 0, m_acc1 = 0;
    Axis_If #(.WIDTH(DW)) din ();
    Axis_If #(.WIDTH(DW)) dout ();
    axis_power #(
        .SAMPLE_WIDTH    (SW),
        .PARALLEL_SAMPLES(PS),
        .SAMPLE_FRAC_BITS(14),
        .PIPE_STAGES     (P),
        .MAX_LOG2_WINDOW (MW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (din),
        .data_out   (dout),
        .mode       (mode_i),
        .log2_window(lw_i)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask
    // Q2.14 squared is Q4.28; the Q4.12 result is floor(x*x / 2^16).
    function automatic logic [SW-1:0] sqf(input logic [SW-1:0] x);
        longint v = longint'($signed(x));
        return SW'((v * v) / 65536);
    endfunction
    task automatic expect_out(input logic [SW-1:0] l1, input logic [SW-1:0] l0, input logic l, input int due);
        exp_t e;
        e.d = {l1, l0};
        e.l = l;
        e.due = due;
        q.push_back(e);
    endtask
    task automatic model(input logic [SW-1:0] x1, input logic [SW-1:0] x0, input logic l);
        if (m_cnt == 0) begin
            m_mode = mode_i;
            m_w = (int'(lw_i) > MW) ? MW : int'(lw_i);
        end
        if (m_mode == MEAN_SQUARE && m_w > 0) begin
            m_acc0 += longint'(sqf(x0));
            m_acc1 += longint'(sqf(x1));
            m_cnt++;
            if (l || m_cnt == (1 << m_w)) begin
                expect_out(SW'(m_acc1 >> m_w), SW'(m_acc0 >> m_w), l, -1);
                m_acc0 = 0;
                m_acc1 = 0;
                m_cnt = 0;
            end
        end else expect_out(sqf(x1), sqf(x0), l, -1);
    endtask
    task automatic send(input logic [SW-1:0] x1, input logic [SW-1:0] x0, input logic l, input int gap, output int acc);
        int t = 0;
        din.valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        din.data = {x1, x0};
        din.last = l;
        din.valid = 1'b1;
        @(negedge clk);
        while (!din.ready) begin
            if (++t > 2000) begin
                $display("FAIL accept_timeout: got no ready expected ready within 2000 cycles");
                $fatal(1);
            end
            @(negedge clk);
        end
        acc = cyc;
        if (use_model) model(x1, x0, l);
        @(posedge clk);
        #1;
        din.valid = 1'b0;
        din.last = 1'b0;
    endtask
    task automatic drain();
        int t = 0;
        while (q.size() > 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", q.size(), 0);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        din.valid = 1'b0;
        din.last = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_valid", dout.valid, 0);
        chk("rst_data", dout.data, 0);
        chk("rst_last", dout.last, 0);
        chk("rst_ready", din.ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_cnt = 0;
        m_acc0 = 0;
        m_acc1 = 0;
        @(negedge clk);
        chk("ready_after_reset", din.ready, 1);
        @(posedge clk);
        #1;
    endtask
    initial begin
        dout.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dout.ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end
    logic          hv = 1'b0;
    logic          hl;
    logic [DW-1:0] hd;
    exp_t          me;
    always @(negedge clk) begin
        if (reset) hv = 1'b0;
        else begin
            if (hv) begin
                chk("hold_valid", dout.valid, 1);
                chk("hold_data", dout.data, hd);
                chk("hold_last", dout.last, hl);
            end
            hv = dout.valid && !dout.ready;
            hd = dout.data;
            hl = dout.last;
            if (dout.valid && dout.ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %h expected no output", dout.data);
                end else begin
                    me = q.pop_front();
                    chk("data", dout.data, me.d);
                    chk("last", dout.last, me.l);
                    if (me.due >= 0) chk("latency", cyc, me.due);
                end
            end
        end
    end
    initial begin
        int n;
        din.valid = 1'b0;
        din.last = 1'b0;
        din.data = '0;
        do_reset();
        send(16'hC000, 16'h4000, 1'b0, 0, n);
        expect_out(16'h1000, 16'h1000, 1'b0, n + P);
        send(16'h2000, 16'h8000, 1'b0, 0, n);
        expect_out(16'h0400, 16'h4000, 1'b0, n + P);
        drain();
        mode_i = MEAN_SQUARE;
        lw_i = WW'(2);
        for (int i = 0; i < 4; i++) send(16'h2000, 16'h4000, 1'b0, 0, n);
        expect_out(16'h0400, 16'h1000, 1'b0, n + P + 1);
        drain();
        send(16'h4000, 16'h4000, 1'b0, 0, n);
        send(16'h4000, 16'h4000, 1'b1, 0, n);
        expect_out(16'h0800, 16'h0800, 1'b1, n + P + 1);
        drain();
        for (int i = 0; i < 3; i++) send(16'h4000, 16'h4000, 1'b0, 0, n);
        do_reset();
        for (int i = 0; i < 4; i++) send(16'h2000, 16'h2000, 1'b0, 0, n);
        expect_out(16'h0400, 16'h0400, 1'b0, n + P + 1);
        drain();
        send(16'h4000, 16'h4000, 1'b0, 0, n);
        lw_i = WW'(1);
        for (int i = 0; i < 3; i++) send(16'h4000, 16'h4000, 1'b0, 0, n);
        expect_out(16'h1000, 16'h1000, 1'b0, n + P + 1);
        for (int i = 0; i < 2; i++) send(16'h2000, 16'h2000, 1'b0, 0, n);
        expect_out(16'h0400, 16'h0400, 1'b0, n + P + 1);
        drain();
        lw_i = WW'(0);
        send(16'hC000, 16'h2000, 1'b1, 0, n);
        expect_out(16'h1000, 16'h0400, 1'b1, n + P);
        drain();
        lw_i = WW'(15);
        for (int i = 0; i < 256; i++) send(16'h8000, 16'h4000, 1'b0, 0, n);
        expect_out(16'h4000, 16'h1000, 1'b0, n + P + 1);
        drain();
        use_model = 1'b1;
        rdy_rand = 1'b1;
        mode_i = SQUARE;
        lw_i = WW'(0);
        for (int i = 0; i < 700; i++)
            send(SW'($urandom), SW'($urandom), $urandom_range(0, 7) == 0, int'($urandom_range(0, 1)), n);
        drain();
        mode_i = MEAN_SQUARE;
        lw_i = WW'(3);
        for (int i = 0; i < 700; i++)
            send(SW'($urandom), SW'($urandom), $urandom_range(0, 7) == 0, int'($urandom_range(0, 1)), n);
        send(SW'($urandom), SW'($urandom), 1'b1, 0, n);
        drain();
        rdy_rand = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
